// File: rtl/fetch_sequencer_if.sv
// Instruction-memory fetch bus between the fetch sequencer (master) and the
// instruction memory (slave).
interface fetch_sequencer_if #(
    parameter int ADDR_W  = 10,
    parameter int INSTR_W = 32
);
    logic               imem_req;
    logic [ADDR_W-1:0]  imem_addr;
    logic               imem_ack;
    logic [INSTR_W-1:0] imem_data;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_data
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_data
    );
endinterface

// File: rtl/fetch_sequencer.sv
// Fetch/execute/update sequencer: fetches from instruction memory, waits for
// the execute stage, then strobes the program counter (sequential or branch).
module fetch_sequencer #(
    parameter int ADDR_W      = 10,
    parameter int INSTR_W     = 32,
    parameter int ACK_TIMEOUT = 15
) (
    input  logic               clock,
    input  logic               CLEAR,
    input  logic               start,
    input  logic [ADDR_W-1:0]  pc_value,
    fetch_sequencer_if.master  imem,
    output logic [INSTR_W-1:0] instr,
    output logic               instr_valid,
    input  logic               exec_done,
    input  logic               branch_taken,
    input  logic [ADDR_W-1:0]  branch_target,
    input  logic               halt,
    output logic               PC_ENABLE,
    output logic               JMP_SGNL,
    output logic [ADDR_W-1:0]  ADDRESS,
    output logic               fault,
    output logic [15:0]        retired,
    output logic [2:0]         state
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] FETCH  = 3'd1;
    localparam logic [2:0] EXEC   = 3'd2;
    localparam logic [2:0] UPDATE = 3'd3;
    localparam logic [2:0] HALTED = 3'd4;
    localparam logic [2:0] FAULT  = 3'd5;

    localparam int              CNT_W     = $clog2(ACK_TIMEOUT + 1);
    // Last zero-ack cycle count before the fetch is declared dead.
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(ACK_TIMEOUT - 1);

    logic              halt_q;
    logic              br_taken_q;
    logic [ADDR_W-1:0] br_target_q;
    logic [CNT_W-1:0]  wait_cnt;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clock or posedge CLEAR) begin
        if (CLEAR) begin
            state       <= IDLE;
            instr       <= '0;
            instr_valid <= 1'b0;
            fault       <= 1'b0;
            retired     <= '0;
            halt_q      <= 1'b0;
            br_taken_q  <= 1'b0;
            br_target_q <= '0;
            wait_cnt    <= '0;
        end else begin
            instr_valid <= 1'b0;
            if (halt && (state == FETCH || state == EXEC || state == UPDATE))
                halt_q <= 1'b1;
            if (state != FETCH)
                wait_cnt <= '0;

            case (state)
                IDLE: if (start) state <= FETCH;
                FETCH: begin
                    if (imem.imem_ack) begin
                        instr       <= imem.imem_data;
                        instr_valid <= 1'b1;
                        state       <= EXEC;
                    end else if (wait_cnt == WAIT_LAST) begin
                        fault <= 1'b1;
                        state <= FAULT;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                EXEC: begin
                    if (exec_done) begin
                        br_taken_q  <= branch_taken;
                        br_target_q <= branch_target;
                        state       <= UPDATE;
                    end
                end
                UPDATE: begin
                    if (retired != 16'hFFFF)
                        retired <= retired + 16'd1;
                    // A halt arriving during UPDATE itself also stops here.
                    state <= (halt_q || halt) ? HALTED : FETCH;
                end
                default: ; // HALTED and FAULT only leave through CLEAR
            endcase
        end
    end

    // Outputs decode straight from state so CLEAR drops them asynchronously.
    // NOTE: every output gets a default first, so no path infers a latch.
    always_comb begin
        imem.imem_req  = 1'b0;
        imem.imem_addr = '0;
        PC_ENABLE      = 1'b0;
        JMP_SGNL       = 1'b0;
        ADDRESS        = '0;
        if (state == FETCH) begin
            imem.imem_req  = 1'b1;
            imem.imem_addr = pc_value;
        end
        if (state == UPDATE) begin
            PC_ENABLE = 1'b1;
            JMP_SGNL  = ~br_taken_q;
            ADDRESS   = br_taken_q ? br_target_q : pc_value;
        end
    end

endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 10, meaning program-address width.
REQ-002 The block SHALL have parameter INSTR_W, default 32, meaning instruction width.
REQ-003 The block SHALL have parameter ACK_TIMEOUT, default 15, meaning maximum wait cycles for imem_ack before fault.
REQ-004 The block SHALL have one clock, `clock`, and one reset, `CLEAR`, which is asynchronous and active-high.
REQ-005 Ports SHALL be as listed, one per line: name, direction, width, meaning.
- clock  in  1  rising-edge clock.
- CLEAR  in  1  async active-high reset.
- start  in  1  leave IDLE and begin fetching.
- pc_value  in  ADDR_W  current program-counter output.
- imem_req  out  1  instruction-fetch request.
- imem_addr  out  ADDR_W  fetch address.
- imem_ack  in  1  fetch data valid this cycle.
- imem_data  in  INSTR_W  fetched instruction.
- instr  out  INSTR_W  instruction register.
- instr_valid  out  1  one-cycle pulse, instr newly loaded.
- exec_done  in  1  execute stage finished the current instruction.
- branch_taken  in  1  sampled with exec_done; redirect the PC.
- branch_target  in  ADDR_W  redirect address.
- halt  in  1  stop after the current instruction retires.
- PC_ENABLE  out  1  program-counter load strobe.
- JMP_SGNL  out  1  1 = sequential advance, 0 = absolute load.
- ADDRESS  out  ADDR_W  address driven to the program counter.
- fault  out  1  sticky fetch-timeout flag.
- retired  out  16  saturating retired-instruction count.
- state  out  3  current FSM state encoding.

Function
REQ-006 The FSM SHALL have the states IDLE=0, FETCH=1, EXEC=2, UPDATE=3, HALTED=4 and FAULT=5, which are the values driven on `state`.
REQ-007 IDLE SHALL go to FETCH on the cycle after `start`=1 is sampled; otherwise it SHALL hold.
REQ-008 In FETCH, the block SHALL drive imem_req=1 and imem_addr=pc_value combinationally.
REQ-009 FETCH+imem_ack=1 SHALL load instr<=imem_data, move to EXEC, and assert instr_valid for exactly the first EXEC cycle.
REQ-010 In FETCH, a wait counter SHALL clear on entry and increment each cycle that imem_ack=0; on reaching ACK_TIMEOUT, the FSM SHALL go to FAULT with fault<=1 and imem_req deasserted.
REQ-011 EXEC SHALL wait for exec_done=1, then capture branch_taken and branch_target into internal registers and go to UPDATE.
REQ-012 An exec_done asserted on the same cycle as instr_valid SHALL be accepted, giving minimum EXEC length 1 cycle.
REQ-013 UPDATE SHALL last exactly one cycle with PC_ENABLE=1.
REQ-014 In UPDATE with a captured taken branch: JMP_SGNL=0, ADDRESS=captured target.
REQ-015 In UPDATE with no branch: JMP_SGNL=1, ADDRESS=pc_value.
REQ-016 In UPDATE, retired SHALL increment by 1 and saturate at 16'hFFFF.
REQ-017 After UPDATE, the FSM SHALL go to HALTED if a halt was latched, else to FETCH.
REQ-018 halt SHALL be latched on any cycle in FETCH/EXEC/UPDATE and cleared by CLEAR only.
REQ-019 A halt seen in FETCH SHALL NOT abort the fetch; the in-flight instruction SHALL complete and retire.
REQ-020 HALTED and FAULT SHALL be terminal; only CLEAR leaves them.
REQ-021 Outside UPDATE: PC_ENABLE=0, JMP_SGNL=0, ADDRESS=0.
REQ-022 Outside FETCH: imem_req=0, imem_addr=0.
REQ-023 imem_ack outside FETCH SHALL be ignored, and instr SHALL be unchanged.
REQ-024 Fetch latency SHALL be ack cycle +1 to EXEC.
REQ-025 Instruction throughput with zero-wait memory and immediate exec_done SHALL be 3 cycles/instruction (FETCH, EXEC, UPDATE).

Reset
REQ-026 While CLEAR=1, the block SHALL force state=IDLE, instr=0, instr_valid=0, PC_ENABLE=0, JMP_SGNL=0, ADDRESS=0, imem_req=0, fault=0, retired=0, and clear the halt latch, branch capture and wait counter.
REQ-027 CLEAR asserted mid-fetch or mid-UPDATE SHALL drop all outputs in the same cycle, asynchronously.
REQ-028 After CLEAR deasserts, the block SHALL wait for a new `start`.

Verification
REQ-029 The bench SHALL check: start pulse, imem_ack on first FETCH cycle, exec_done on first EXEC cycle, branch_taken=0, pc_value=5 -> instr_valid one cycle later; UPDATE shows PC_ENABLE=1, JMP_SGNL=1, ADDRESS=5; retired=1; back to FETCH.
REQ-030 The bench SHALL check: exec_done with branch_taken=1, branch_target=10'h3A0, with branch_taken dropping the next cycle -> UPDATE shows JMP_SGNL=0, ADDRESS=10'h3A0.
REQ-031 The bench SHALL check: imem_ack held 0 for ACK_TIMEOUT cycles -> state=FAULT, fault=1, imem_req=0, stays until CLEAR.
REQ-032 The bench SHALL check: halt pulsed during FETCH with ack 3 cycles later -> instruction retires (retired +1), then state=HALTED, no further imem_req.
REQ-033 The bench SHALL check: CLEAR asserted during UPDATE -> PC_ENABLE falls immediately, state=IDLE, retired=0, and a later start resumes normally.
REQ-034 The bench SHALL check: retired preloaded near saturation via 65,536 back-to-back retirements -> retired holds at 16'hFFFF.
